cmp_share_sched: RTL and testbench
==================================

# cmp_share_sched

Round-robin scheduler that shares a single 1-bit magnitude-compare slice between two requesters. Each granted request is resolved bit-serially, MSB first, with early termination at the first differing bit. The block sits between two client blocks needing WIDTH-bit Gt/Eq/Lt decisions and the area-cheap serial compare datapath. It trades latency for area against a full parallel comparator.

## Interface
- `WIDTH`, default 8: operand width in bits, legal range ≥ 2.
- `clk`  in  1  clock; all state changes on its rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `req0`  in  1  port 0 request, level-sensitive.
- `a0`, `b0`  in  WIDTH  port 0 operands, unsigned.
- `req1`  in  1  port 1 request, level-sensitive.
- `a1`, `b1`  in  WIDTH  port 1 operands, unsigned.
- `done0`  out  1  one-cycle pulse: port 0 result valid.
- `done1`  out  1  one-cycle pulse: port 1 result valid.
- `Gt`, `Eq`, `Lt`  out  1 each  shared result (A>B, A==B, A<B) of the most recent transaction.
- `busy`  out  1  high while a transaction is in flight.

## Operation
- FSM states:
  - IDLE: `busy`=0; samples `req0` and `req1`.
    - If neither is high: stay in IDLE.
    - If exactly one is high: grant it.
    - If both are high: grant the port opposite to `last_grant`.
    - On grant: capture the granted A and B into internal registers, store the grant id, update `last_grant`, set index = WIDTH-1, go to SCAN.
  - SCAN: `busy`=1; evaluate captured A[idx] and B[idx] with the 1-bit slice (gt = a&~b, lt = ~a&b).
    - gt=1: set result Gt, go to DONE.
    - lt=1: set result Lt, go to DONE.
    - Bits equal and idx = 0: set result Eq, go to DONE.
    - Otherwise: decrement idx, stay in SCAN.
  - DONE: `busy`=1; pulse `done0` or `done1` for the granted port; go to IDLE.
- Gt/Eq/Lt:
  - Updated only on the edge entering DONE.
  - Held until the next DONE.
  - Exactly one is high after the first transaction.
- Operands are captured at grant; changes on `a*`/`b*` after the grant edge have no effect.
- Client handshake:
  - Raise `req` with stable operands.
  - Hold `req` until `done` is seen.
  - Drop `req` in the cycle `done` is high; if `req` is still high in the following IDLE, a new transaction starts.
- A non-granted port's request is not lost. It remains pending, since `req` is level, and is served in the next IDLE.
- Reset:
  - Outputs: `done0`, `done1`, `Gt`, `Eq`, `Lt`, `busy` = 0.
  - State: FSM = IDLE, `last_grant` = 1, so port 0 wins the first tie.
- Reset asserted mid-SCAN or mid-DONE:
  - All outputs clear immediately, asynchronously.
  - No `done` pulse is issued for the aborted transaction.
  - After release, the pending request is restarted from scratch.

## Timing
- Let k be the number of bits examined: 1 + (WIDTH-1 - index of the highest differing bit), or WIDTH when the operands are equal.
- Edge E0 (req sampled in IDLE): FSM enters SCAN.
- SCAN lasts k cycles.
- `done` is high for exactly one cycle, starting at edge E0+k+1.
- Latency range: minimum 2 cycles (MSB differs), maximum WIDTH+1 cycles.
- The next grant can occur no earlier than edge E0+k+2 (one IDLE cycle between transactions).
- `done0` and `done1` are never high together.
- `busy` goes high at E0+1 and low at E0+k+2.
- Both ports requesting continuously: grants strictly alternate 0,1,0,1,…

## Test plan
- Late difference, WIDTH=8: `req0`, `a0`=0xA5, `b0`=0xA4 → k=8, `done0` at E0+9, Gt=1, Eq=0, Lt=0, `done1` never asserted.
- MSB early exit: `req1`, `a1`=0x7F, `b1`=0x80 → k=1, `done1` at E0+2, Lt=1; `busy` high for exactly 2 cycles.
- Equal operands: `req0`, `a0`=`b0`=0x3C → k=8, `done0` at E0+9, Eq=1; results hold through 5 idle cycles.
- Contention: both `req` held after reset, `a0`=1, `b0`=2, `a1`=9, `b1`=3 → grant order 0,1,0,1:
  - port 0 results are Lt=1;
  - port 1 results are Gt=1;
  - one IDLE cycle between `done` and the next `busy` rise.
- Operand change: after a `req0` grant with `a0`=0x10, `b0`=0x01, change `a0` to 0x00 during SCAN → result is still Gt=1.
- Reset mid-SCAN: drop `rst_n` at E0+3 of an 8-cycle compare → all outputs 0 immediately, no `done`. After release with `req0` still high, `done0` follows k+1 cycles after the first post-reset sampling edge.

Source files
------------

// File: rtl/cmp_share_sched.sv
// Round-robin sharing of one 1-bit magnitude-compare slice between two requesters.
// Each grant is resolved MSB-first with early exit on the first differing bit.
module cmp_share_sched #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    output logic             done0,
    output logic             done1,
    output logic             Gt,
    output logic             Eq,
    output logic             Lt,
    output logic             busy
);
    localparam int IW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_e;

    state_e           state_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [IW-1:0]    idx_q;
    logic             gid_q;
    logic             last_q;

    logic a_bit, b_bit, bit_gt, bit_lt;
    logic gnt_vld, gnt_id;

    assign a_bit  = a_q[idx_q];
    assign b_bit  = b_q[idx_q];
    assign bit_gt = a_bit & ~b_bit;
    assign bit_lt = ~a_bit & b_bit;

    // On a tie the port that did not win last time gets the slice.
    assign gnt_vld = req0 | req1;
    assign gnt_id  = (req0 & req1) ? ~last_q : req1;

    // busy/done are registered from the current state, so they lag it by one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            idx_q   <= '0;
            gid_q   <= 1'b0;
            last_q  <= 1'b1;
            done0   <= 1'b0;
            done1   <= 1'b0;
            Gt      <= 1'b0;
            Eq      <= 1'b0;
            Lt      <= 1'b0;
            busy    <= 1'b0;
        end else begin
            busy  <= (state_q != IDLE);
            done0 <= (state_q == DONE) && !gid_q;
            done1 <= (state_q == DONE) &&  gid_q;
            case (state_q)
                IDLE: begin
                    if (gnt_vld) begin
                        a_q     <= gnt_id ? a1 : a0;
                        b_q     <= gnt_id ? b1 : b0;
                        gid_q   <= gnt_id;
                        last_q  <= gnt_id;
                        idx_q   <= IW'(WIDTH - 1);
                        state_q <= SCAN;
                    end
                end
                SCAN: begin
                    if (bit_gt) begin
                        {Gt, Eq, Lt} <= 3'b100;
                        state_q      <= DONE;
                    end else if (bit_lt) begin
                        {Gt, Eq, Lt} <= 3'b001;
                        state_q      <= DONE;
                    end else if (idx_q == '0) begin
                        {Gt, Eq, Lt} <= 3'b010;
                        state_q      <= DONE;
                    end else begin
                        idx_q <= idx_q - 1'b1;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cmp_share_sched.sv
// Directed plus randomized checks of cmp_share_sched against a plain arithmetic reference.
module tb_cmp_share_sched;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req0 = 1'b0, req1 = 1'b0;
    logic [W-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic         done0, done1, Gt, Eq, Lt, busy;

    int total = 0;
    int bad   = 0;

    cmp_share_sched #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .a0(a0), .b0(b0),
        .req1(req1), .a1(a1), .b1(b1),
        .done0(done0), .done1(done1),
        .Gt(Gt), .Eq(Eq), .Lt(Lt), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        total++;
        assert (obs === want) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    // Bits examined: down to and including the highest differing bit, all of them if equal.
    function automatic int ref_k(input logic [W-1:0] a, input logic [W-1:0] b);
        for (int i = W - 1; i >= 0; i--)
            if (a[i] != b[i]) return W - i;
        return W;
    endfunction

    function automatic logic [2:0] ref_res(input logic [W-1:0] a, input logic [W-1:0] b);
        if (a > b) return 3'b100;
        if (a == b) return 3'b010;
        return 3'b001;
    endfunction

    task automatic set_port(input bit p, input logic r, input logic [W-1:0] a, input logic [W-1:0] b);
        if (p) begin req1 = r; a1 = a; b1 = b; end
        else   begin req0 = r; a0 = a; b0 = b; end
    endtask

    // Called at a negedge with the block idle and the request already raised.
    task automatic watch(input string tg, input bit p, input logic [W-1:0] a,
                         input logic [W-1:0] b, input bit mutate);
        int k = ref_k(a, b);
        logic [2:0] res = ref_res(a, b);
        for (int n = 0; n <= k + 2; n++) begin
            @(negedge clk);
            chk({tg, "_busy"}, busy, (n >= 1 && n <= k + 1));
            chk({tg, "_done_own"}, p ? done1 : done0, (n == k + 1));
            chk({tg, "_done_other"}, p ? done0 : done1, 0);
            if (n == k + 1) begin
                chk({tg, "_result"}, {Gt, Eq, Lt}, res);
                if (p) req1 = 1'b0; else req0 = 1'b0;
            end
            if (mutate && n == 1) begin
                if (p) a1 = '0; else a0 = '0;
            end
        end
    endtask

    task automatic single(input string tg, input bit p, input logic [W-1:0] a,
                          input logic [W-1:0] b, input bit mutate);
        set_port(p, 1'b1, a, b);
        watch(tg, p, a, b, mutate);
    endtask

    initial begin
        bit           p;
        logic [W-1:0] ra, rb;
        int           ndone, since;

        #2;
        chk("reset_outs", {done0, done1, Gt, Eq, Lt, busy}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        single("late_diff", 0, 8'hA5, 8'hA4, 0);
        single("msb_exit", 1, 8'h7F, 8'h80, 0);
        single("equal", 0, 8'h3C, 8'h3C, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("eq_hold", {Gt, Eq, Lt}, 3'b010);
            chk("eq_idle_busy", busy, 0);
        end
        single("op_change", 0, 8'h10, 8'h01, 1);

        for (int i = 0; i < 24; i++) begin
            p  = 1'($urandom_range(0, 1));
            ra = W'($urandom);
            case ($urandom_range(0, 3))
                0:       rb = ra;
                1:       rb = ra ^ (8'h01 << $urandom_range(0, 7));
                default: rb = W'($urandom);
            endcase
            single("rand", p, ra, rb, 0);
        end

        // Contention: both ports request continuously from reset.
        rst_n = 1'b0;
        @(negedge clk);
        chk("cont_reset", {done0, done1, Gt, Eq, Lt, busy}, 0);
        rst_n = 1'b1;
        set_port(0, 1'b1, 8'd1, 8'd2);
        set_port(1, 1'b1, 8'd9, 8'd3);
        ndone = 0;
        since = -1;
        for (int cyc = 0; cyc < 200 && ndone < 4; cyc++) begin
            @(negedge clk);
            chk("cont_both_done", done0 & done1, 0);
            if (done0 | done1) begin
                chk("cont_order", done1, ndone % 2);
                chk("cont_result", {Gt, Eq, Lt},
                    done1 ? ref_res(8'd9, 8'd3) : ref_res(8'd1, 8'd2));
                ndone++;
                since = 0;
                if (ndone == 4) begin req0 = 1'b0; req1 = 1'b0; end
            end else if (since >= 0) begin
                since++;
                if (since == 1) chk("cont_gap_idle", busy, 0);
                if (since == 2) chk("cont_busy_rise", busy, 1);
            end
        end
        chk("cont_count", ndone, 4);
        repeat (2) @(negedge clk);

        // Reset in the middle of an 8-bit scan, then restart from scratch.
        set_port(0, 1'b1, 8'h55, 8'h55);
        repeat (4) @(posedge clk);
        #1;
        chk("rst_pre_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("rst_async", {done0, done1, Gt, Eq, Lt, busy}, 0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("rst_held", {done0, done1, Gt, Eq, Lt, busy}, 0);
        end
        rst_n = 1'b1;
        watch("rst_restart", 0, 8'h55, 8'h55, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
